light_phase_monitor: RTL

// - Receive side of the controller-to-signal-head interface: samples main_light/side_light

---
 rtl/traffic_pkg.sv | 55 +++++
 rtl/lamp_decoder.sv | 25 ++
 rtl/light_phase_monitor.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared controller/signal-head definitions: light codes, monitor phases,
// fault codes and one-hot lamp patterns.
package traffic_pkg;

    typedef enum logic [1:0] {
        OFF = 2'd0,
        GRN = 2'd1,
        YEL = 2'd2,
        RED = 2'd3
    } light_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_G_R,
        ST_Y_R,
        ST_R_G,
        ST_R_Y,
        ST_FAULT
    } phase_t;

    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_ILLEGAL   = 3'd1;
    localparam logic [2:0] FC_SEQ       = 3'd2;
    localparam logic [2:0] FC_YEL_SHORT = 3'd3;
    localparam logic [2:0] FC_YEL_LONG  = 3'd4;
    localparam logic [2:0] FC_GRN_LONG  = 3'd5;

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_RED = 3'b100;

    // {main, side} code pairs
    localparam logic [3:0] PAIR_OFF = {OFF, OFF};
    localparam logic [3:0] PAIR_GR  = {GRN, RED};
    localparam logic [3:0] PAIR_YR  = {YEL, RED};
    localparam logic [3:0] PAIR_RG  = {RED, GRN};
    localparam logic [3:0] PAIR_RY  = {RED, YEL};

    // Tracked phase that displays a given pair; ST_INIT means "not a legal phase pair".
    function automatic phase_t pair_phase(input logic [3:0] pair);
        case (pair)
            PAIR_GR: return ST_G_R;
            PAIR_YR: return ST_Y_R;
            PAIR_RG: return ST_R_G;
            PAIR_RY: return ST_R_Y;
            default: return ST_INIT;
        endcase
    endfunction

    function automatic logic pair_legal(input logic [3:0] pair);
        return pair_phase(pair) != ST_INIT;
    endfunction

endpackage

// File: rtl/lamp_decoder.sv
// Light code to one-hot {red,yel,grn} lamp drive; flash mode forces a blinking red.
module lamp_decoder
    import traffic_pkg::*;
(
    input  logic [1:0] i_code,
    input  logic       i_flash,
    input  logic       i_blink,
    output logic [2:0] o_lamp
);

    always_comb begin
        o_lamp = LAMP_OFF;
        if (i_flash) begin
            o_lamp = {i_blink, 2'b00};
        end else begin
            case (light_t'(i_code))
                GRN:     o_lamp = LAMP_GRN;
                YEL:     o_lamp = LAMP_YEL;
                RED:     o_lamp = LAMP_RED;
                default: o_lamp = LAMP_OFF;
            endcase
        end
    end

endmodule

// File: rtl/light_phase_monitor.sv
// Signal-head receiver: registers controller light codes, checks the phase
// sequence and dwell limits, drives lamps, and latches a flashing-red fault.
module light_phase_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned YEL_MIN    = 2,
    parameter int unsigned YEL_MAX    = 4,
    parameter int unsigned GRN_MAX    = 16,
    parameter int unsigned BLINK_HALF = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       main_light,
    input  logic [1:0]       side_light,
    input  logic             fault_clr,
    output logic [2:0]       main_lamp,
    output logic [2:0]       side_lamp,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [CNT_W-1:0] phase_time,
    output logic             phase_valid
);

    localparam logic [CNT_W-1:0] C_YEL_MIN = CNT_W'(YEL_MIN);
    localparam logic [CNT_W-1:0] C_YEL_MAX = CNT_W'(YEL_MAX);
    localparam logic [CNT_W-1:0] C_GRN_MAX = CNT_W'(GRN_MAX);
    localparam logic [CNT_W-1:0] C_BLK_END = CNT_W'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    logic [3:0]       r_in_q;
    phase_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_from_init;
    logic [2:0]       r_code;
    logic [CNT_W-1:0] r_phase_time;
    logic             r_phase_valid;
    logic             r_blink;
    logic [CNT_W-1:0] r_blink_cnt;

    phase_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_from_init_nxt;
    logic [2:0]       w_code_nxt;
    logic             w_pv_nxt;
    logic [3:0]       w_cur_pair;
    logic [3:0]       w_next_pair;
    logic             w_is_yel;
    logic             w_flash;

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_q        <= PAIR_OFF;
            r_state       <= ST_INIT;
            r_cnt         <= '0;
            r_from_init   <= 1'b0;
            r_code        <= FC_NONE;
            r_phase_time  <= '0;
            r_phase_valid <= 1'b0;
            r_blink       <= 1'b0;
            r_blink_cnt   <= '0;
        end else begin
            r_in_q        <= {main_light, side_light};
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_from_init   <= w_from_init_nxt;
            r_code        <= w_code_nxt;
            r_phase_valid <= w_pv_nxt;
            if (w_pv_nxt)
                r_phase_time <= r_cnt;
            // Preloaded to 1 outside FAULT so the flash always starts lit.
            if (r_state != ST_FAULT) begin
                r_blink     <= 1'b1;
                r_blink_cnt <= '0;
            end else if (r_blink_cnt == C_BLK_END) begin
                r_blink     <= ~r_blink;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_cur_pair  = PAIR_OFF;
        w_next_pair = PAIR_OFF;
        w_is_yel    = 1'b0;
        case (r_state)
            ST_G_R: begin w_cur_pair = PAIR_GR; w_next_pair = PAIR_YR; end
            ST_Y_R: begin w_cur_pair = PAIR_YR; w_next_pair = PAIR_RG; w_is_yel = 1'b1; end
            ST_R_G: begin w_cur_pair = PAIR_RG; w_next_pair = PAIR_RY; end
            ST_R_Y: begin w_cur_pair = PAIR_RY; w_next_pair = PAIR_GR; w_is_yel = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_from_init_nxt = r_from_init;
        w_code_nxt      = r_code;
        w_pv_nxt        = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (pair_legal(r_in_q)) begin
                    w_state_nxt     = pair_phase(r_in_q);
                    w_cnt_nxt       = C_ONE;
                    w_from_init_nxt = 1'b1;
                end else if (r_in_q != PAIR_OFF) begin
                    w_state_nxt = ST_FAULT;
                    w_code_nxt  = FC_ILLEGAL;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    w_state_nxt = ST_INIT;
                    w_code_nxt  = FC_NONE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                if (r_in_q == w_cur_pair) begin
                    if (w_is_yel && r_cnt == C_YEL_MAX) begin
                        w_state_nxt = ST_FAULT;
                        w_code_nxt  = FC_YEL_LONG;
                    end else if (!w_is_yel && r_cnt == C_GRN_MAX) begin
                        w_state_nxt = ST_FAULT;
                        w_code_nxt  = FC_GRN_LONG;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else if (r_in_q == w_next_pair) begin
                    // A phase entered from INIT is partial: no min-dwell check, no report.
                    if (w_is_yel && !r_from_init && r_cnt < C_YEL_MIN) begin
                        w_state_nxt = ST_FAULT;
                        w_code_nxt  = FC_YEL_SHORT;
                    end else begin
                        w_state_nxt     = pair_phase(w_next_pair);
                        w_cnt_nxt       = C_ONE;
                        w_from_init_nxt = 1'b0;
                        w_pv_nxt        = !r_from_init;
                    end
                end else if (pair_legal(r_in_q) || r_in_q == PAIR_OFF) begin
                    w_state_nxt = ST_FAULT;
                    w_code_nxt  = FC_SEQ;
                end else begin
                    w_state_nxt = ST_FAULT;
                    w_code_nxt  = FC_ILLEGAL;
                end
            end
        endcase
    end

    assign w_flash = (r_state == ST_FAULT);

    lamp_decoder u_main_dec (
        .i_code  (w_cur_pair[3:2]),
        .i_flash (w_flash),
        .i_blink (r_blink),
        .o_lamp  (main_lamp)
    );

    lamp_decoder u_side_dec (
        .i_code  (w_cur_pair[1:0]),
        .i_flash (w_flash),
        .i_blink (r_blink),
        .o_lamp  (side_lamp)
    );

    assign fault       = w_flash;
    assign fault_code  = r_code;
    assign phase_time  = r_phase_time;
    assign phase_valid = r_phase_valid;

endmodule
